// File: rtl/regwb_pkg.sv
// Shared types for the register-file writeback arbiter: request payload and grant encoding.
package regwb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;
endpackage

// File: rtl/regwb_fifo.sv
// Small per-source request FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  wb_req_t                din,
    output wb_req_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (A) and load/multi-cycle (B) writeback.
// Optional REGWB_ZERO_DROP_EN: popped requests targeting register 0 use their slot but never assert rw.
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              rw,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] datawritten,
    output logic              idle
);
    wb_req_t                req_a, req_b, head_a, head_b, win;
    logic [$clog2(DEPTH):0] cnt_a, cnt_b;
    logic                   full_a, full_b, empty_a, empty_b;
    logic                   push_a, push_b, pop_a, pop_b, any_pop, do_write;
    grant_t                 gnt, last_gnt;

    assign req_a = '{addr: a_reg, data: a_data};
    assign req_b = '{addr: b_reg, data: b_data};

    // Ready comes from the registered count only, so a full FIFO refuses even while popping.
    assign a_ready = ~full_a;
    assign b_ready = ~full_b;
    assign push_a  = a_valid & a_ready;
    assign push_b  = b_valid & b_ready;

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .din(req_a),
        .head(head_a), .count(cnt_a), .full(full_a), .empty(empty_a)
    );

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .din(req_b),
        .head(head_b), .count(cnt_b), .full(full_b), .empty(empty_b)
    );

    always_comb begin
        gnt      = GNT_A;
        any_pop  = ~empty_a | ~empty_b;
        if (~empty_a & ~empty_b) begin
            gnt = (last_gnt == GNT_A) ? GNT_B : GNT_A;
        end else if (~empty_b) begin
            gnt = GNT_B;
        end
        pop_a    = any_pop & (gnt == GNT_A);
        pop_b    = any_pop & (gnt == GNT_B);
        win      = (gnt == GNT_A) ? head_a : head_b;
`ifdef REGWB_ZERO_DROP_EN
        do_write = any_pop & (win.addr != '0);
`else
        do_write = any_pop;
`endif
    end

    // Reset starts the pointer on B so A wins the first tie; rw clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw          <= 1'b0;
            writereg    <= '0;
            datawritten <= '0;
            last_gnt    <= GNT_B;
        end else begin
            rw <= do_write;
            if (any_pop) begin
                last_gnt <= gnt;
            end
            if (do_write) begin
                writereg    <= win.addr;
                datawritten <= win.data;
            end
        end
    end

    assign idle = (cnt_a == '0) & (cnt_b == '0) & ~rw;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-level reference model plus a negedge register-file monitor.
module tb_regfile_wb_arbiter;
    import regwb_pkg::*;

    localparam int DEPTH = 2;
`ifdef REGWB_ZERO_DROP_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg = '0, b_reg = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        rw, idle;
    logic [4:0]  writereg;
    logic [31:0] datawritten;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .rw(rw), .writereg(writereg), .datawritten(datawritten), .idle(idle)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: per-source request lists, drained by the drivers as handshakes complete.
    wb_req_t a_src[$], b_src[$];
    int      a_rate = 100, b_rate = 100;
    bit      hold_valid = 1'b0;
    bit      a_rdy_s = 1'b0, b_rdy_s = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            a_valid = hold_valid;
            a_rdy_s = 1'b0;
        end else begin
            if (a_valid && a_rdy_s && a_src.size() > 0) void'(a_src.pop_front());
            if (a_src.size() > 0 && $urandom_range(99) < a_rate) begin
                a_valid = 1'b1; a_reg = a_src[0].addr; a_data = a_src[0].data;
            end else begin
                a_valid = 1'b0; a_reg = 5'($urandom); a_data = $urandom;
            end
            a_rdy_s = a_ready;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            b_valid = hold_valid;
            b_rdy_s = 1'b0;
        end else begin
            if (b_valid && b_rdy_s && b_src.size() > 0) void'(b_src.pop_front());
            if (b_src.size() > 0 && $urandom_range(99) < b_rate) begin
                b_valid = 1'b1; b_reg = b_src[0].addr; b_data = b_src[0].data;
            end else begin
                b_valid = 1'b0; b_reg = 5'($urandom); b_data = $urandom;
            end
            b_rdy_s = b_ready;
        end
    end

    // Reference model: two queues, one write slot per cycle, alternate on contention.
    wb_req_t mq_a[$], mq_b[$], exp_q[$];
    bit      exp_rw = 1'b0;
    int      last_g = 1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq_a.delete(); mq_b.delete(); exp_q.delete();
            exp_rw = 1'b0;
            last_g = 1;
        end else begin
            bit      ra, rb;
            int      g;
            wb_req_t w;
            ra = (mq_a.size() != DEPTH);
            rb = (mq_b.size() != DEPTH);
            g  = -1;
            if (mq_a.size() > 0 && mq_b.size() > 0) g = 1 - last_g;
            else if (mq_a.size() > 0) g = 0;
            else if (mq_b.size() > 0) g = 1;
            exp_rw = 1'b0;
            if (g >= 0) begin
                last_g = g;
                w = (g == 0) ? mq_a.pop_front() : mq_b.pop_front();
                if (!(ZD && w.addr == 5'd0)) begin
                    exp_rw = 1'b1;
                    exp_q.push_back(w);
                end
            end
            if (a_valid && ra) mq_a.push_back(wb_req_t'{addr: a_reg, data: a_data});
            if (b_valid && rb) mq_b.push_back(wb_req_t'{addr: b_reg, data: b_data});
        end
    end

    // Monitor: the register file commits on the negedge; compare every cycle against the model.
    logic [31:0] rf [32];
    int          wr_log[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_rw", rw, 0);
            chk("rst_a_ready", a_ready, 1);
            chk("rst_b_ready", b_ready, 1);
            chk("rst_idle", idle, 1);
        end else begin
            chk("rw", rw, exp_rw);
            chk("a_ready", a_ready, mq_a.size() != DEPTH);
            chk("b_ready", b_ready, mq_b.size() != DEPTH);
            chk("idle", idle, mq_a.size() == 0 && mq_b.size() == 0 && !exp_rw);
            if (exp_rw && exp_q.size() > 0) begin
                wb_req_t w;
                w = exp_q.pop_front();
                chk("writereg", writereg, w.addr);
                chk("datawritten", datawritten, w.data);
            end
            if (rw) begin
                rf[writereg] = datawritten;
                wr_log.push_back(int'(writereg));
            end
        end
    end

    task automatic push_req(input bit src, input int r, input int d);
        if (src) b_src.push_back(wb_req_t'{addr: 5'(r), data: 32'(d)});
        else     a_src.push_back(wb_req_t'{addr: 5'(r), data: 32'(d)});
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (a_src.size() == 0 && b_src.size() == 0 && !a_valid && !b_valid &&
                mq_a.size() == 0 && mq_b.size() == 0 && !exp_rw) break;
            if (n > 2000) begin
                errors++; checks++;
                $display("FAIL drain_timeout: actual=busy required=idle at %0t", $time);
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int e[$]);
        chk({name, "_len"}, wr_log.size(), e.size());
        for (int i = 0; i < e.size() && i < wr_log.size(); i++) chk(name, wr_log[i], e[i]);
    endtask

    initial begin
        int e[$];
        int n;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset held with valids asserted: nothing may enter.
        hold_valid = 1'b1;
        repeat (2) @(negedge clk);
        hold_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;

        push_req(0, 9, 32'h5);
        wait_idle();
        chk("t1_rf9", rf[9], 32'h5);
        e.delete(); e.push_back(9);
        chk_log("t1_order", e);

        // Contention from a fresh reset: A wins first tie, then strict alternation.
        do_reset();
        wr_log.delete();
        for (int i = 1; i <= 4; i++) begin
            push_req(0, i, 32'h100 + i);
            push_req(1, 10 + i, 32'h200 + i);
        end
        wait_idle();
        e.delete();
        for (int i = 1; i <= 4; i++) begin e.push_back(i); e.push_back(10 + i); end
        chk_log("t2_order", e);

        wr_log.delete();
        for (int i = 1; i <= 6; i++) push_req(0, i, 32'h300 + i);
        wait_idle();
        e.delete();
        for (int i = 1; i <= 6; i++) e.push_back(i);
        chk_log("t3_order", e);

        // Same destination at both heads: later grant (B) must survive.
        do_reset();
        push_req(0, 7, 32'h10);
        push_req(1, 7, 32'h20);
        wait_idle();
        chk("t4_rf7", rf[7], 32'h20);

        // Asynchronous reset while streaming.
        for (int i = 0; i < 4; i++) begin
            push_req(0, 16 + i, $urandom);
            push_req(1, 24 + i, $urandom);
        end
        n = 0;
        while (!(mq_a.size() + mq_b.size() >= 3 && exp_rw) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_busy", n < 50, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        a_src.delete(); b_src.delete();
        #1;
        chk("t5_async_rw", rw, 0);
        chk("t5_async_idle", idle, 1);
        wr_log.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("t5_stale_writes", wr_log.size(), 0);
        chk("t5_idle", idle, 1);

        // Register 0 handling.
        rf[0] = '0;
        wr_log.delete();
        push_req(0, 0, 32'hFF);
        push_req(0, 3, 32'h1);
        wait_idle();
        chk("t6_rf0", rf[0], ZD ? 32'h0 : 32'hFF);
        chk("t6_rf3", rf[3], 32'h1);
        e.delete();
        if (!ZD) e.push_back(0);
        e.push_back(3);
        chk_log("t6_order", e);

        // Randomized traffic with varying offered load.
        for (int blk = 0; blk < 4; blk++) begin
            a_rate = $urandom_range(20, 100);
            b_rate = $urandom_range(20, 100);
            for (int i = 0; i < 50; i++) begin
                push_req(0, $urandom_range(31), $urandom);
                push_req(1, $urandom_range(31), $urandom);
            end
            wait_idle();
        end
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
